// File: rtl/upsampler_h_0_sched.sv
// Horizontal x2 upsampler sequencer: zero-stuffed 1x3 windows plus col/row tags.
// UPSAMPLER_EDGE_ZERO_EN selects zero padding instead of replication at the right edge.
module upsampler_h_0_sched #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [FP_WIDTH_REG-1:0]                data_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic [0:0][0:2][FP_WIDTH_REG-1:0]      window_o,
  output logic [0:0][0:2][FP_WIDTH_REG-1:0]      kernel_o,
  output logic [15:0]                            col_o,
  output logic [15:0]                            row_o,
  output logic                                   valid_o,
  output logic                                   frame_done_o
);

  typedef enum logic [2:0] {
    S_FIRST,
    S_EVEN,
    S_NEXT,
    S_ODD,
    S_LAST
  } state_t;

  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] OUT_LAST = 16'(2 * IMAGE_WIDTH - 1);
  localparam logic [FP_WIDTH_REG-1:0] ZERO = '0;

  state_t                  state_q, state_d;
  logic [FP_WIDTH_REG-1:0] cur_q, cur_d;
  logic [FP_WIDTH_REG-1:0] prev_q, prev_d;
  logic [15:0]             in_col_q, in_col_d;
  logic [15:0]             row_q, row_d;
  logic                    accept;
  logic [FP_WIDTH_REG-1:0] edge_px;
  logic [15:0]             col_x2;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_FIRST;
      cur_q    <= '0;
      prev_q   <= '0;
      in_col_q <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      in_col_q <= in_col_d;
      row_q    <= row_d;
    end
  end

  assign accept = valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    prev_d   = prev_q;
    in_col_d = in_col_q;
    row_d    = row_q;
    unique case (state_q)
      S_FIRST: begin
        if (accept) begin
          cur_d    = data_i;
          in_col_d = '0;
          state_d  = S_EVEN;
        end
      end
      S_EVEN, S_NEXT: begin
        if (state_q == S_EVEN && in_col_q == LAST_COL) begin
          state_d = S_LAST;
        end else if (accept) begin
          prev_d   = cur_q;
          cur_d    = data_i;
          in_col_d = in_col_q + 16'd1;
          state_d  = S_ODD;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ODD: begin
        state_d = S_EVEN;
      end
      S_LAST: begin
        row_d = (row_q == LAST_ROW) ? 16'd0 : row_q + 16'd1;
        if (accept) begin
          cur_d    = data_i;
          in_col_d = '0;
          state_d  = S_EVEN;
        end else begin
          state_d = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

`ifdef UPSAMPLER_EDGE_ZERO_EN
  assign edge_px = ZERO;
`else
  assign edge_px = cur_q;
`endif

  assign col_x2 = {in_col_q[14:0], 1'b0};

  always_comb begin
    ready_o        = 1'b0;
    valid_o        = 1'b0;
    frame_done_o   = 1'b0;
    col_o          = '0;
    window_o       = '0;
    unique case (state_q)
      S_FIRST: ready_o = 1'b1;
      S_NEXT:  ready_o = 1'b1;
      S_EVEN: begin
        ready_o        = (in_col_q < LAST_COL);
        valid_o        = 1'b1;
        col_o          = col_x2;
        window_o[0][1] = cur_q;
      end
      S_ODD: begin
        valid_o        = 1'b1;
        col_o          = col_x2 - 16'd1;
        window_o[0][0] = prev_q;
        window_o[0][2] = cur_q;
      end
      S_LAST: begin
        ready_o        = 1'b1;
        valid_o        = 1'b1;
        frame_done_o   = (row_q == LAST_ROW);
        col_o          = OUT_LAST;
        window_o[0][0] = cur_q;
        window_o[0][2] = edge_px;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Row tag is the register itself, so S_LAST shows the pre-increment row.
  assign row_o = row_q;

  assign kernel_o[0][0] = FP_WIDTH_REG'(16'h3800);
  assign kernel_o[0][1] = FP_WIDTH_REG'(16'h3C00);
  assign kernel_o[0][2] = FP_WIDTH_REG'(16'h3800);

endmodule

// File: tb/tb_upsampler_h_0_sched.sv
// Scoreboard bench for upsampler_h_0_sched with a 4x2 image.
// Expected windows are queued by stimulus and popped by an output monitor.
module tb_upsampler_h_0_sched;

  localparam int W = 4;
  localparam int H = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [15:0]              data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [0:0][0:2][15:0]    window_o;
  logic [0:0][0:2][15:0]    kernel_o;
  logic [15:0]              col_o;
  logic [15:0]              row_o;
  logic                     valid_o;
  logic                     frame_done_o;

  upsampler_h_0_sched #(
    .EXP_WIDTH   (5),
    .FRAC_WIDTH  (10),
    .FP_WIDTH_REG(16),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .window_o    (window_o),
    .kernel_o    (kernel_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .valid_o     (valid_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef logic [15:0] line_t [W];
  line_t L0 = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  line_t L1 = '{16'h4500, 16'hC000, 16'h3800, 16'h0001};
  line_t L2 = '{16'h7BFF, 16'h8000, 16'h3555, 16'h4248};

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int col, input int row,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic fd);
    exp_t e;
    e.col = 16'(col);
    e.row = 16'(row);
    e.w0  = a;
    e.w1  = b;
    e.w2  = c;
    e.fd  = fd;
    return e;
  endfunction

  task automatic push_line(input line_t p, input int row);
    logic [15:0] edge_px;
    for (int c = 0; c < W; c++) begin
      q.push_back(mk(2 * c, row, 16'h0, p[c], 16'h0, 1'b0));
      if (c < W - 1) begin
        q.push_back(mk(2 * c + 1, row, p[c], 16'h0, p[c+1], 1'b0));
      end else begin
`ifdef UPSAMPLER_EDGE_ZERO_EN
        edge_px = 16'h0000;
`else
        edge_px = p[c];
`endif
        q.push_back(mk(2 * c + 1, row, p[c], 16'h0, edge_px, row == H - 1));
      end
    end
  endtask

  // Holds px until the DUT accepts it; gaps randomly drop valid_i.
  task automatic drive_px(input logic [15:0] px, input bit gaps);
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_i);
      data_i  = px;
      valid_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (valid_i && ready_o) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL drive_timeout: got no accept expected accept of %h", px);
    end
  endtask

  task automatic send_line(input line_t p, input bit gaps);
    for (int i = 0; i < W; i++) drive_px(p[i], gaps);
  endtask

  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk_i);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en && valid_o) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: got col %0d row %0d expected none",
                 col_o, row_o);
      end else begin
        e = q.pop_front();
        if (col_o !== e.col || row_o !== e.row ||
            window_o[0][0] !== e.w0 || window_o[0][1] !== e.w1 ||
            window_o[0][2] !== e.w2 || frame_done_o !== e.fd) begin
          errors++;
          $display("FAIL window: got col %0d row %0d {%h,%h,%h} fd %b expected col %0d row %0d {%h,%h,%h} fd %b",
                   col_o, row_o, window_o[0][0], window_o[0][1],
                   window_o[0][2], frame_done_o, e.col, e.row,
                   e.w0, e.w1, e.w2, e.fd);
        end
      end
    end
  end

  logic [8:0] rdy_exp;

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Reset in the middle of a line
    drive_px(16'h1234, 1'b0);
    drive_px(16'h5678, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 16'(valid_o), 16'h0);
    chk("rst_fd", 16'(frame_done_o), 16'h0);
    chk("rst_col", col_o, 16'h0);
    chk("rst_row", row_o, 16'h0);
    chk("rst_win0", window_o[0][0], 16'h0);
    chk("rst_win1", window_o[0][1], 16'h0);
    chk("rst_win2", window_o[0][2], 16'h0);
    chk("kernel0", kernel_o[0][0], 16'h3800);
    chk("kernel1", kernel_o[0][1], 16'h3C00);
    chk("kernel2", kernel_o[0][2], 16'h3800);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 16'(ready_o), 16'h1);
    chk("post_rst_valid", 16'(valid_o), 16'h0);
    mon_en = 1'b1;

    // Continuous line with ready_o pattern
    push_line(L0, 0);
    rdy_exp = 9'b1_0010_1011;
    begin
      int idx = 0;
      for (int i = 0; i < 9; i++) begin
        if (i > 0) @(negedge clk_i);
        chk($sformatf("ready_%0d", i), 16'(ready_o), 16'(rdy_exp[i]));
        valid_i = (idx < W);
        data_i  = (idx < W) ? L0[idx] : 16'h0;
        if (valid_i && ready_o) idx++;
      end
    end
    idle();
    drain();

    // Same line with random valid gaps, row 1 ends the frame
    push_line(L0, 1);
    send_line(L0, 1'b1);
    idle();
    drain();

    // Two back-to-back lines, then a wrapped third line
    push_line(L1, 0);
    push_line(L2, 1);
    send_line(L1, 1'b0);
    send_line(L2, 1'b0);
    idle();
    drain();
    push_line(L0, 0);
    send_line(L0, 1'b0);
    idle();
    drain();

    // Reset two pixels into row 1
    mon_en = 1'b0;
    drive_px(16'hAAAA, 1'b0);
    drive_px(16'hBBBB, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    rst_i  = 1'b1;
    mon_en = 1'b1;
    push_line(L1, 0);
    send_line(L1, 1'b0);
    idle();
    drain();

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
